// File: rtl/ins_pre_decoder_pkg.sv
// Shared types for the instruction pre-decoder: FSM states, queue-entry record
// and the MCS-51 opcode-length lookup.
package ins_pre_decoder_pkg;

   // Widest program counter the queue-entry record can carry.
   localparam int unsigned PcWMax = 32;

   typedef enum logic [1:0] {
      StOpc,
      StOp1,
      StOp2
   } pd_state_e;

   typedef struct packed {
      logic [7:0]        opcode;
      logic [7:0]        op1;
      logic [7:0]        op2;
      logic [1:0]        len;
      logic [PcWMax-1:0] pc;
   } ins_entry_t;

   function automatic logic [1:0] ins_len(input logic [7:0] opc);
      logic [1:0] len;
      len = 2'd1;
      if (opc[3:0] == 4'h1) begin
         len = 2'd2;  // AJMP / ACALL
      end else begin
         case (opc) inside
            8'h02, 8'h10, 8'h12, 8'h20, 8'h30, 8'h43, 8'h53, 8'h63, 8'h75, 8'h85, 8'h90,
            8'hD5, [8'hB4:8'hBF]: len = 2'd3;
            8'h05, 8'h15, 8'h24, 8'h25, 8'h34, 8'h35, 8'h40, 8'h42, 8'h44, 8'h45, 8'h50,
            8'h52, 8'h54, 8'h55, 8'h60, 8'h62, 8'h64, 8'h65, 8'h70, 8'h72, 8'h74, 8'h76,
            8'h77, 8'h80, 8'h82, 8'h86, 8'h87, 8'h92, 8'h94, 8'h95, 8'hA0, 8'hA2, 8'hA6,
            8'hA7, 8'hB0, 8'hB2, 8'hC0, 8'hC2, 8'hC5, 8'hD0, 8'hD2, 8'hE5, 8'hF5,
            [8'h78:8'h7F], [8'h88:8'h8F], [8'hA8:8'hAF], [8'hD8:8'hDF]: len = 2'd2;
            default: len = 2'd1;
         endcase
      end
      return len;
   endfunction

endpackage

// File: rtl/ins_queue.sv
// Synchronous FIFO for decoded instruction entries; clr_i empties it and
// overrides any push or pop in the same cycle.
module ins_queue #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 8,
   localparam int unsigned PtrW = $clog2(Depth),
   localparam int unsigned CntW = $clog2(Depth + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [Width-1:0] data_o,
   output logic [CntW-1:0]  count_o,
   output logic             empty_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  count_q;
   logic             full, push_ok, pop_ok;

   assign empty_o = (count_q == '0);
   assign full    = (count_q == CntW'(Depth));
   assign push_ok = push_i && !full;
   assign pop_ok  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= wr_ptr_q + PtrW'(1);
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         if (push_ok && !pop_ok) begin
            count_q <= count_q + CntW'(1);
         end else if (pop_ok && !push_ok) begin
            count_q <= count_q - CntW'(1);
         end
      end
   end

endmodule

// File: rtl/ins_pre_decoder.sv
// Assembles MCS-51 code bytes into whole instructions (opcode, operands,
// length, address) and queues them for the consumer.
module ins_pre_decoder
   import ins_pre_decoder_pkg::*;
#(
   parameter int unsigned QDEPTH = 4,
   parameter int unsigned PC_W   = 16,
   localparam int unsigned CntW  = $clog2(QDEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [7:0]      in_byte,
   output logic            in_ready,
   input  logic            flush,
   input  logic [PC_W-1:0] flush_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [7:0]      out_opcode,
   output logic [7:0]      out_op1,
   output logic [7:0]      out_op2,
   output logic [1:0]      out_len,
   output logic [PC_W-1:0] out_pc,
   output logic [CntW-1:0] q_count
);

   pd_state_e       state_q;
   logic [7:0]      opc_q, op1_q;
   logic [1:0]      len_q;
   logic [PC_W-1:0] ins_pc_q, fetch_pc_q;
   logic            accept, push, pop, q_empty;
   logic [1:0]      byte_len;
   ins_entry_t      push_entry, head_entry;
   logic            unused_head_pc;

   // Only queue occupancy and flush gate the input; out_ready never reaches here.
   assign in_ready = !flush && (q_count < CntW'(QDEPTH));
   assign accept   = in_valid && in_ready;
   assign byte_len = ins_len(in_byte);
   assign pop      = out_valid && out_ready;

   always_comb begin
      push       = 1'b0;
      push_entry = '0;
      case (state_q)
         StOpc: begin
            push              = accept && (byte_len == 2'd1);
            push_entry.opcode = in_byte;
            push_entry.len    = 2'd1;
            push_entry.pc     = PcWMax'(fetch_pc_q);
         end
         StOp1: begin
            push              = accept && (len_q == 2'd2);
            push_entry.opcode = opc_q;
            push_entry.op1    = in_byte;
            push_entry.len    = 2'd2;
            push_entry.pc     = PcWMax'(ins_pc_q);
         end
         StOp2: begin
            push              = accept;
            push_entry.opcode = opc_q;
            push_entry.op1    = op1_q;
            push_entry.op2    = in_byte;
            push_entry.len    = 2'd3;
            push_entry.pc     = PcWMax'(ins_pc_q);
         end
         default: push = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StOpc;
         opc_q      <= '0;
         op1_q      <= '0;
         len_q      <= '0;
         ins_pc_q   <= '0;
         fetch_pc_q <= '0;
      end else if (flush) begin
         state_q    <= StOpc;
         fetch_pc_q <= flush_pc;
      end else if (accept) begin
         fetch_pc_q <= fetch_pc_q + PC_W'(1);
         case (state_q)
            StOpc: begin
               opc_q    <= in_byte;
               len_q    <= byte_len;
               ins_pc_q <= fetch_pc_q;
               state_q  <= (byte_len == 2'd1) ? StOpc : StOp1;
            end
            StOp1: begin
               op1_q   <= in_byte;
               state_q <= (len_q == 2'd2) ? StOpc : StOp2;
            end
            default: state_q <= StOpc;
         endcase
      end
   end

   ins_queue #(
      .Depth(QDEPTH),
      .Width($bits(ins_entry_t))
   ) u_queue (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (flush),
      .push_i (push),
      .data_i (push_entry),
      .pop_i  (pop),
      .data_o (head_entry),
      .count_o(q_count),
      .empty_o(q_empty)
   );

   assign out_valid      = !q_empty;
   assign out_opcode     = out_valid ? head_entry.opcode : '0;
   assign out_op1        = out_valid ? head_entry.op1 : '0;
   assign out_op2        = out_valid ? head_entry.op2 : '0;
   assign out_len        = out_valid ? head_entry.len : '0;
   assign out_pc         = out_valid ? head_entry.pc[PC_W-1:0] : '0;
   assign unused_head_pc = ^head_entry.pc;

endmodule

// File: tb/tb_ins_pre_decoder.sv
// Directed self-checking bench for ins_pre_decoder.
module tb_ins_pre_decoder;

   localparam int unsigned QDEPTH = 4;
   localparam int unsigned PC_W   = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic [7:0]      in_byte = 8'h00;
   logic            flush = 1'b0;
   logic [PC_W-1:0] flush_pc = '0;
   logic            out_ready = 1'b0;
   logic            in_ready, out_valid;
   logic [7:0]      out_opcode, out_op1, out_op2;
   logic [1:0]      out_len;
   logic [PC_W-1:0] out_pc;
   logic [2:0]      q_count;
   logic [42:0]     head;
   int              n_tests = 0;
   int              n_fail = 0;

   always #5 clk = ~clk;

   assign head = {out_valid, out_opcode, out_op1, out_op2, out_len, out_pc};

   ins_pre_decoder #(.QDEPTH(QDEPTH), .PC_W(PC_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_byte   (in_byte),
      .in_ready  (in_ready),
      .flush     (flush),
      .flush_pc  (flush_pc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_opcode(out_opcode),
      .out_op1   (out_op1),
      .out_op2   (out_op2),
      .out_len   (out_len),
      .out_pc    (out_pc),
      .q_count   (q_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [7:0] b);
      in_valid = 1'b1;
      in_byte  = b;
      step();
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      if (head !== 43'h0) begin $display("FAIL reset_head: got %h expected %h", head, 43'h0); n_fail++; end
      n_tests++;
      if (q_count !== 3'd0) begin $display("FAIL reset_count: got %0d expected 0", q_count); n_fail++; end
      n_tests++;
      rst_n = 1'b1;
      #1;
      if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready: got %b expected 1", in_ready); n_fail++; end
      n_tests++;
      feed(8'h00);
      if (head !== {1'b1, 8'h00, 8'h00, 8'h00, 2'd1, 16'h0000}) begin
         $display("FAIL first_nop: got %h expected %h", head, {1'b1, 8'h00, 8'h00, 8'h00, 2'd1, 16'h0000}); n_fail++;
      end
      n_tests++;
   endtask

   task automatic test_reset_mid_instr();
      do_reset();
      feed(8'h02);
      feed(8'h12);
      #2 rst_n = 1'b0;
      #1;
      if (head !== 43'h0 || q_count !== 3'd0) begin
         $display("FAIL mid_reset_clear: got head %h count %0d expected 0/0", head, q_count); n_fail++;
      end
      n_tests++;
      rst_n = 1'b1;
      step();
      feed(8'h00);
      if (head !== {1'b1, 8'h00, 8'h00, 8'h00, 2'd1, 16'h0000}) begin
         $display("FAIL mid_reset_restart: got %h expected %h", head, {1'b1, 8'h00, 8'h00, 8'h00, 2'd1, 16'h0000}); n_fail++;
      end
      n_tests++;
   endtask

   task automatic test_multi_byte();
      do_reset();
      out_ready = 1'b1;
      feed(8'h02);
      if (out_valid !== 1'b0) begin $display("FAIL ljmp_partial: got %b expected 0", out_valid); n_fail++; end
      n_tests++;
      feed(8'h12);
      feed(8'h34);
      if (head !== {1'b1, 8'h02, 8'h12, 8'h34, 2'd3, 16'h0000}) begin
         $display("FAIL ljmp_entry: got %h expected %h", head, {1'b1, 8'h02, 8'h12, 8'h34, 2'd3, 16'h0000}); n_fail++;
      end
      n_tests++;
      feed(8'h74);
      if (out_valid !== 1'b0) begin $display("FAIL ljmp_popped: got %b expected 0", out_valid); n_fail++; end
      n_tests++;
      feed(8'h55);
      if (head !== {1'b1, 8'h74, 8'h55, 8'h00, 2'd2, 16'h0003}) begin
         $display("FAIL mov_imm_entry: got %h expected %h", head, {1'b1, 8'h74, 8'h55, 8'h00, 2'd2, 16'h0003}); n_fail++;
      end
      n_tests++;
      step();
      if (q_count !== 3'd0) begin $display("FAIL drain_count: got %0d expected 0", q_count); n_fail++; end
      n_tests++;
      out_ready = 1'b0;
   endtask

   task automatic test_bubble();
      do_reset();
      feed(8'h02);
      step();
      step();
      feed(8'h12);
      step();
      if (out_valid !== 1'b0) begin $display("FAIL bubble_partial: got %b expected 0", out_valid); n_fail++; end
      n_tests++;
      feed(8'h34);
      if (head !== {1'b1, 8'h02, 8'h12, 8'h34, 2'd3, 16'h0000}) begin
         $display("FAIL bubble_entry: got %h expected %h", head, {1'b1, 8'h02, 8'h12, 8'h34, 2'd3, 16'h0000}); n_fail++;
      end
      n_tests++;
   endtask

   task automatic test_lengths();
      logic [7:0] opcs [13] = '{8'h00, 8'h11, 8'h12, 8'h85, 8'h90, 8'hB4, 8'hBF,
                                8'hD8, 8'hDF, 8'hE4, 8'hA5, 8'h75, 8'h74};
      logic [1:0] lens [13] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3,
                                2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd2};
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 13; i++) begin
         feed(opcs[i]);
         for (int k = 1; k < int'(lens[i]); k++) feed(8'hEE);
         if (out_valid !== 1'b1 || out_opcode !== opcs[i] || out_len !== lens[i]) begin
            $display("FAIL len_%h: got valid %b opc %h len %0d expected 1 %h %0d",
                     opcs[i], out_valid, out_opcode, out_len, opcs[i], lens[i]);
            n_fail++;
         end
         n_tests++;
      end
      out_ready = 1'b0;
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < int'(QDEPTH); i++) feed(8'h00);
      if (q_count !== 3'd4 || in_ready !== 1'b0) begin
         $display("FAIL full_state: got count %0d in_ready %b expected 4 0", q_count, in_ready); n_fail++;
      end
      n_tests++;
      feed(8'hE4);
      if (q_count !== 3'd4 || out_pc !== 16'h0000) begin
         $display("FAIL full_hold: got count %0d pc %h expected 4 0000", q_count, out_pc); n_fail++;
      end
      n_tests++;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      if (q_count !== 3'd3 || in_ready !== 1'b1 || out_pc !== 16'h0001) begin
         $display("FAIL full_pop: got count %0d in_ready %b pc %h expected 3 1 0001",
                  q_count, in_ready, out_pc);
         n_fail++;
      end
      n_tests++;
   endtask

   task automatic test_flush();
      do_reset();
      feed(8'h00);
      feed(8'h02);
      feed(8'h12);
      flush = 1'b1; flush_pc = 16'h0100; in_valid = 1'b1; in_byte = 8'h99; out_ready = 1'b1;
      #1;
      if (in_ready !== 1'b0) begin $display("FAIL flush_in_ready: got %b expected 0", in_ready); n_fail++; end
      n_tests++;
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      if (head !== 43'h0 || q_count !== 3'd0) begin
         $display("FAIL flush_clear: got head %h count %0d expected 0/0", head, q_count); n_fail++;
      end
      n_tests++;
      feed(8'h04);
      if (head !== {1'b1, 8'h04, 8'h00, 8'h00, 2'd1, 16'h0100} || q_count !== 3'd1) begin
         $display("FAIL flush_redirect: got %h count %0d expected %h 1",
                  head, q_count, {1'b1, 8'h04, 8'h00, 8'h00, 2'd1, 16'h0100});
         n_fail++;
      end
      n_tests++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      feed(8'h00);
      feed(8'hE4);
      out_ready = 1'b1;
      feed(8'h04);
      if (q_count !== 3'd2 || head !== {1'b1, 8'hE4, 8'h00, 8'h00, 2'd1, 16'h0001}) begin
         $display("FAIL b2b_push_pop: got count %0d head %h expected 2 %h",
                  q_count, head, {1'b1, 8'hE4, 8'h00, 8'h00, 2'd1, 16'h0001});
         n_fail++;
      end
      n_tests++;
      step();
      if (q_count !== 3'd1 || head !== {1'b1, 8'h04, 8'h00, 8'h00, 2'd1, 16'h0002}) begin
         $display("FAIL b2b_order: got count %0d head %h expected 1 %h",
                  q_count, head, {1'b1, 8'h04, 8'h00, 8'h00, 2'd1, 16'h0002});
         n_fail++;
      end
      n_tests++;
      step();
      out_ready = 1'b0;
      if (q_count !== 3'd0 || head !== 43'h0) begin
         $display("FAIL b2b_empty: got count %0d head %h expected 0 0", q_count, head); n_fail++;
      end
      n_tests++;
   endtask

   task automatic test_pc_wrap();
      do_reset();
      flush = 1'b1; flush_pc = 16'hFFFF;
      step();
      flush = 1'b0;
      feed(8'h75);
      feed(8'hAA);
      feed(8'hBB);
      if (head !== {1'b1, 8'h75, 8'hAA, 8'hBB, 2'd3, 16'hFFFF}) begin
         $display("FAIL wrap_entry: got %h expected %h", head, {1'b1, 8'h75, 8'hAA, 8'hBB, 2'd3, 16'hFFFF}); n_fail++;
      end
      n_tests++;
      feed(8'h00);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      if (head !== {1'b1, 8'h00, 8'h00, 8'h00, 2'd1, 16'h0002}) begin
         $display("FAIL wrap_next_pc: got %h expected %h", head, {1'b1, 8'h00, 8'h00, 8'h00, 2'd1, 16'h0002}); n_fail++;
      end
      n_tests++;
   endtask

   initial begin
      test_reset();
      test_reset_mid_instr();
      test_multi_byte();
      test_bubble();
      test_lengths();
      test_full();
      test_flush();
      test_back_to_back();
      test_pc_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
